// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared widths, control-bit bundle and the write-through match helper for the ID/EX register.
package id_ex_pipeline_register_pkg;
  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 4;
  localparam int STALL_CNT_W  = 32;
  localparam int REG_IDX_W    = 5;

  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write_enable;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // WB writing a nonzero rd that the decode instruction is reading this cycle
  function automatic logic wb_hit(input logic we, input logic [REG_IDX_W-1:0] wb_rd,
                                  input logic [REG_IDX_W-1:0] rs);
    return we && (wb_rd != '0) && (wb_rd == rs);
  endfunction
endpackage

// File: rtl/id_ex_pipeline_register_load_use_detector.sv
// Combinational load-use compare: a load in EX whose rd is read by the decode instruction.
module load_use_detector
  import id_ex_pipeline_register_pkg::*;
(
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_read_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 id_valid_i,
  input  logic                 id_uses_rs_0_i,
  input  logic                 id_uses_rs_1_i,
  input  logic [REG_IDX_W-1:0] id_rs_0_i,
  input  logic [REG_IDX_W-1:0] id_rs_1_i,
  output logic                 load_use_o
);
  logic hit_0, hit_1;

  assign hit_0      = id_uses_rs_0_i && (ex_rd_i == id_rs_0_i);
  assign hit_1      = id_uses_rs_1_i && (ex_rd_i == id_rs_1_i);
  assign load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && id_valid_i
                      && (hit_0 || hit_1);
endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: latches decode outputs, inserts load-use bubbles, honours flush/hold.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int XLEN         = id_ex_pipeline_register_pkg::XLEN,
  parameter int ALU_OP_WIDTH = id_ex_pipeline_register_pkg::ALU_OP_WIDTH,
  parameter int STALL_CNT_W  = id_ex_pipeline_register_pkg::STALL_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ID_valid,
  input  logic [XLEN-1:0]         ID_pc,
  input  logic [4:0]              ID_read_register_0,
  input  logic [4:0]              ID_read_register_1,
  input  logic                    ID_uses_rs_0,
  input  logic                    ID_uses_rs_1,
  input  logic [4:0]              ID_destination_register,
  input  logic [XLEN-1:0]         ID_read_data_0,
  input  logic [XLEN-1:0]         ID_read_data_1,
  input  logic [XLEN-1:0]         ID_immediate,
  input  logic [ALU_OP_WIDTH-1:0] ID_alu_op,
  input  logic                    ID_alu_src,
  input  logic                    ID_mem_read,
  input  logic                    ID_mem_write,
  input  logic                    ID_mem_to_reg,
  input  logic                    ID_reg_write_enable,
  input  logic                    WB_reg_write_enable,
  input  logic [4:0]              WB_destination_register,
  input  logic [XLEN-1:0]         WB_write_data,
  input  logic                    flush,
  input  logic                    hold,
  output logic                    EX_valid,
  output logic [XLEN-1:0]         EX_pc,
  output logic [4:0]              EX_read_register_0,
  output logic [4:0]              EX_read_register_1,
  output logic                    EX_uses_rs_0,
  output logic                    EX_uses_rs_1,
  output logic [4:0]              EX_destination_register,
  output logic [XLEN-1:0]         EX_read_data_0,
  output logic [XLEN-1:0]         EX_read_data_1,
  output logic [XLEN-1:0]         EX_immediate,
  output logic [ALU_OP_WIDTH-1:0] EX_alu_op,
  output logic                    EX_alu_src,
  output logic                    EX_mem_read,
  output logic                    EX_mem_write,
  output logic                    EX_mem_to_reg,
  output logic                    EX_reg_write_enable,
  output logic                    ID_stall,
  output logic [STALL_CNT_W-1:0]  stall_count
);
  logic                    valid_q, valid_d;
  logic [XLEN-1:0]         pc_q, pc_d, d0_q, d0_d, d1_q, d1_d, imm_q, imm_d;
  logic [4:0]              rs0_q, rs0_d, rs1_q, rs1_d, rd_q, rd_d;
  logic                    u0_q, u0_d, u1_q, u1_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  ctrl_t                   ctrl_q, ctrl_d, ctrl_in;
  logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    load_use, bubble;

  load_use_detector u_lud (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_rd_i        (rd_q),
    .id_valid_i     (ID_valid),
    .id_uses_rs_0_i (ID_uses_rs_0),
    .id_uses_rs_1_i (ID_uses_rs_1),
    .id_rs_0_i      (ID_read_register_0),
    .id_rs_1_i      (ID_read_register_1),
    .load_use_o     (load_use)
  );

  assign ctrl_in = '{alu_src: ID_alu_src, mem_read: ID_mem_read, mem_write: ID_mem_write,
                     mem_to_reg: ID_mem_to_reg, reg_write_enable: ID_reg_write_enable};
  // flush beats hold; a load-use bubble is only inserted when the pipe is not frozen
  assign bubble   = flush || (!hold && load_use);
  assign ID_stall = load_use && !flush;

  always_comb begin
    valid_d = valid_q; pc_d = pc_q; rs0_d = rs0_q; rs1_d = rs1_q; u0_d = u0_q; u1_d = u1_q;
    rd_d = rd_q; d0_d = d0_q; d1_d = d1_q; imm_d = imm_q; op_d = op_q; ctrl_d = ctrl_q;
    cnt_d = cnt_q;
    if (bubble) begin
      valid_d = 1'b0; pc_d = '0; rs0_d = '0; rs1_d = '0; u0_d = 1'b0; u1_d = 1'b0;
      rd_d = '0; d0_d = '0; d1_d = '0; imm_d = '0; op_d = '0; ctrl_d = CTRL_BUBBLE;
    end else if (!hold) begin
      valid_d = ID_valid;
      pc_d    = ID_pc;
      rs0_d   = ID_read_register_0;
      rs1_d   = ID_read_register_1;
      u0_d    = ID_uses_rs_0;
      u1_d    = ID_uses_rs_1;
      rd_d    = ID_destination_register;
      d0_d    = wb_hit(WB_reg_write_enable, WB_destination_register, ID_read_register_0)
                ? WB_write_data : ID_read_data_0;
      d1_d    = wb_hit(WB_reg_write_enable, WB_destination_register, ID_read_register_1)
                ? WB_write_data : ID_read_data_1;
      imm_d   = ID_immediate;
      op_d    = ID_alu_op;
      ctrl_d  = ID_valid ? ctrl_in : CTRL_BUBBLE;
    end
    if (!flush && !hold && load_use && (cnt_q != '1)) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0; pc_q <= '0; rs0_q <= '0; rs1_q <= '0; u0_q <= 1'b0; u1_q <= 1'b0;
      rd_q <= '0; d0_q <= '0; d1_q <= '0; imm_q <= '0; op_q <= '0; ctrl_q <= CTRL_BUBBLE;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d; pc_q <= pc_d; rs0_q <= rs0_d; rs1_q <= rs1_d; u0_q <= u0_d;
      u1_q <= u1_d; rd_q <= rd_d; d0_q <= d0_d; d1_q <= d1_d; imm_q <= imm_d; op_q <= op_d;
      ctrl_q <= ctrl_d; cnt_q <= cnt_d;
    end
  end

  assign EX_valid                = valid_q;
  assign EX_pc                   = pc_q;
  assign EX_read_register_0      = rs0_q;
  assign EX_read_register_1      = rs1_q;
  assign EX_uses_rs_0            = u0_q;
  assign EX_uses_rs_1            = u1_q;
  assign EX_destination_register = rd_q;
  assign EX_read_data_0          = d0_q;
  assign EX_read_data_1          = d1_q;
  assign EX_immediate            = imm_q;
  assign EX_alu_op               = op_q;
  assign EX_alu_src              = ctrl_q.alu_src;
  assign EX_mem_read             = ctrl_q.mem_read;
  assign EX_mem_write            = ctrl_q.mem_write;
  assign EX_mem_to_reg           = ctrl_q.mem_to_reg;
  assign EX_reg_write_enable     = ctrl_q.reg_write_enable;
  assign stall_count             = cnt_q;
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register: instruction-level model checked every negedge.
module tb_id_ex_pipeline_register;
  localparam int CW = 3;  // small counter so saturation is reachable

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs0, rs1, rd;
    logic        u0, u1;
    logic [31:0] d0, d1, imm;
    logic [3:0]  op;
    logic        alu_src, mrd, mwr, m2r, we;
  } ins_t;

  logic clk = 0, reset_n = 0, flush = 0, hold = 0;
  logic wb_en = 0; logic [4:0] wb_rd = 0; logic [31:0] wb_data = 0;
  ins_t cur, m;
  logic [CW-1:0] mcnt;
  int n_tests = 0, n_fail = 0;

  logic        EX_valid, EX_uses_rs_0, EX_uses_rs_1, EX_alu_src, EX_mem_read, EX_mem_write;
  logic        EX_mem_to_reg, EX_reg_write_enable, ID_stall;
  logic [31:0] EX_pc, EX_read_data_0, EX_read_data_1, EX_immediate;
  logic [4:0]  EX_read_register_0, EX_read_register_1, EX_destination_register;
  logic [3:0]  EX_alu_op;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.XLEN(32), .ALU_OP_WIDTH(4), .STALL_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ID_valid(cur.valid), .ID_pc(cur.pc),
    .ID_read_register_0(cur.rs0), .ID_read_register_1(cur.rs1),
    .ID_uses_rs_0(cur.u0), .ID_uses_rs_1(cur.u1), .ID_destination_register(cur.rd),
    .ID_read_data_0(cur.d0), .ID_read_data_1(cur.d1), .ID_immediate(cur.imm),
    .ID_alu_op(cur.op), .ID_alu_src(cur.alu_src), .ID_mem_read(cur.mrd),
    .ID_mem_write(cur.mwr), .ID_mem_to_reg(cur.m2r), .ID_reg_write_enable(cur.we),
    .WB_reg_write_enable(wb_en), .WB_destination_register(wb_rd), .WB_write_data(wb_data),
    .flush(flush), .hold(hold),
    .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_read_register_0(EX_read_register_0),
    .EX_read_register_1(EX_read_register_1), .EX_uses_rs_0(EX_uses_rs_0),
    .EX_uses_rs_1(EX_uses_rs_1), .EX_destination_register(EX_destination_register),
    .EX_read_data_0(EX_read_data_0), .EX_read_data_1(EX_read_data_1),
    .EX_immediate(EX_immediate), .EX_alu_op(EX_alu_op), .EX_alu_src(EX_alu_src),
    .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write), .EX_mem_to_reg(EX_mem_to_reg),
    .EX_reg_write_enable(EX_reg_write_enable), .ID_stall(ID_stall), .stall_count(stall_count)
  );

  function automatic ins_t nop();
    ins_t b;
    b = '{valid: 0, pc: 0, rs0: 0, rs1: 0, rd: 0, u0: 0, u1: 0, d0: 0, d1: 0, imm: 0,
          op: 0, alu_src: 0, mrd: 0, mwr: 0, m2r: 0, we: 0};
    return b;
  endfunction

  // lw rd, imm(rs1)
  function automatic ins_t lw(input logic [31:0] pc, input logic [4:0] rd);
    ins_t i = nop();
    i.valid = 1; i.pc = pc; i.rs0 = 5'd1; i.u0 = 1; i.rd = rd; i.d0 = 32'h100;
    i.imm = 32'h8; i.op = 4'h0; i.alu_src = 1; i.mrd = 1; i.m2r = 1; i.we = 1;
    return i;
  endfunction

  // add rd, rs1, rs2
  function automatic ins_t add(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [4:0] a, input logic [4:0] b);
    ins_t i = nop();
    i.valid = 1; i.pc = pc; i.rs0 = a; i.rs1 = b; i.u0 = 1; i.u1 = 1; i.rd = rd;
    i.d0 = 32'h11; i.d1 = 32'h22; i.op = 4'h1; i.we = 1;
    return i;
  endfunction

  // Stall rule stated at instruction level: a valid load in EX writes a register the decode
  // instruction genuinely reads.
  function automatic logic model_stall();
    logic reads;
    reads = (cur.u0 && cur.rs0 == m.rd) || (cur.u1 && cur.rs1 == m.rd);
    return m.valid && m.mrd && m.rd != 0 && cur.valid && reads && !flush;
  endfunction

  always @(posedge clk) begin
    ins_t nxt;
    if (!reset_n) begin
      m = nop(); mcnt = 0;
    end else if (flush) begin
      m = nop();
    end else if (!hold) begin
      if (model_stall()) begin
        m = nop();
        if (mcnt != {CW{1'b1}}) mcnt = mcnt + 1;
      end else begin
        nxt = cur;
        if (wb_en && wb_rd != 0 && wb_rd == cur.rs0) nxt.d0 = wb_data;
        if (wb_en && wb_rd != 0 && wb_rd == cur.rs1) nxt.d1 = wb_data;
        if (!cur.valid) begin
          nxt.alu_src = 0; nxt.mrd = 0; nxt.mwr = 0; nxt.m2r = 0; nxt.we = 0;
        end
        m = nxt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("EX_valid", 32'(EX_valid), 32'(m.valid));
    chk("EX_pc", EX_pc, m.pc);
    chk("EX_rs0", 32'(EX_read_register_0), 32'(m.rs0));
    chk("EX_rs1", 32'(EX_read_register_1), 32'(m.rs1));
    chk("EX_uses", 32'({EX_uses_rs_0, EX_uses_rs_1}), 32'({m.u0, m.u1}));
    chk("EX_rd", 32'(EX_destination_register), 32'(m.rd));
    chk("EX_data0", EX_read_data_0, m.d0);
    chk("EX_data1", EX_read_data_1, m.d1);
    chk("EX_imm", EX_immediate, m.imm);
    chk("EX_alu_op", 32'(EX_alu_op), 32'(m.op));
    chk("EX_ctrl", 32'({EX_alu_src, EX_mem_read, EX_mem_write, EX_mem_to_reg, EX_reg_write_enable}),
        32'({m.alu_src, m.mrd, m.mwr, m.m2r, m.we}));
    chk("stall_count", 32'(stall_count), 32'(mcnt));
    chk("ID_stall", 32'(ID_stall), 32'(model_stall()));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held_pc;
    // T1: reset with busy inputs
    cur = add(32'h40, 5'd9, 5'd3, 5'd4); cur.mrd = 1; wb_en = 1; wb_rd = 5'd3; wb_data = 32'hFF;
    reset_n = 0; tick(); tick();
    chk("T1 valid", 32'(EX_valid), 0); chk("T1 pc", EX_pc, 0); chk("T1 cnt", 32'(stall_count), 0);
    wb_en = 0; reset_n = 1;

    // T2: lw x5 then add x6,x5,x1
    cur = lw(32'h100, 5'd5); tick();
    chk("T2 ld rd", 32'(EX_destination_register), 5);
    cur = add(32'h104, 5'd6, 5'd5, 5'd1); #1;
    chk("T2 stall", 32'(ID_stall), 1);
    tick();
    chk("T2 bubble", 32'(EX_valid), 0); chk("T2 cnt", 32'(stall_count), 1);
    chk("T2 unstall", 32'(ID_stall), 0);
    tick();
    chk("T2 add rd", 32'(EX_destination_register), 6); chk("T2 add pc", EX_pc, 32'h104);

    // T3: lui x5 does not read rs1; lw x0 never stalls
    cur = lw(32'h108, 5'd5); tick();
    cur = nop(); cur.valid = 1; cur.pc = 32'h10C; cur.rs0 = 5'd5; cur.rd = 5'd5;
    cur.imm = 32'h12345000; cur.we = 1; #1;
    chk("T3 lui stall", 32'(ID_stall), 0);
    tick();
    chk("T3 lui imm", EX_immediate, 32'h12345000);
    cur = lw(32'h110, 5'd0); tick();
    cur = add(32'h114, 5'd2, 5'd0, 5'd0); #1;
    chk("T3 x0 stall", 32'(ID_stall), 0);
    tick();

    // T4: flush wins over load-use
    cur = lw(32'h118, 5'd5); tick();
    cur = add(32'h11C, 5'd6, 5'd5, 5'd1); flush = 1; #1;
    chk("T4 stall", 32'(ID_stall), 0);
    tick(); flush = 0;
    chk("T4 bubble", 32'(EX_valid), 0); chk("T4 cnt", 32'(stall_count), 1);

    // T5: hold freezes EX and the counter even with load-use pending
    cur = lw(32'h120, 5'd5); tick();
    held_pc = EX_pc; hold = 1;
    for (int i = 0; i < 3; i++) begin
      cur = add(32'h200 + 32'(4 * i), 5'd6, 5'd5, 5'd7); tick();
    end
    chk("T5 pc", EX_pc, held_pc); chk("T5 cnt", 32'(stall_count), 1);
    hold = 0; tick();
    chk("T5 post cnt", 32'(stall_count), 2);
    tick();

    // T6: write-through from WB
    cur = add(32'h130, 5'd8, 5'd7, 5'd7);
    wb_en = 1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF; tick();
    chk("T6 wt0", EX_read_data_0, 32'hDEADBEEF); chk("T6 wt1", EX_read_data_1, 32'hDEADBEEF);
    cur = add(32'h134, 5'd8, 5'd7, 5'd3); wb_rd = 5'd0; tick();
    chk("T6 x0 keep", EX_read_data_0, 32'h11);
    cur = add(32'h138, 5'd8, 5'd2, 5'd7); wb_rd = 5'd7; wb_data = 32'hCAFE0001; tick();
    chk("T6 rs1 only", EX_read_data_1, 32'hCAFE0001); chk("T6 rs0 kept", EX_read_data_0, 32'h11);
    wb_en = 0;

    // invalid decode: fields load, control forced off
    cur = lw(32'h13C, 5'd9); cur.valid = 0; cur.u0 = 0; tick();
    chk("inv ctrl", 32'(EX_reg_write_enable), 0); chk("inv pc", EX_pc, 32'h13C);

    // saturation of the stall counter
    for (int i = 0; i < 7; i++) begin
      cur = lw(32'h300 + 32'(8 * i), 5'd5); tick();
      cur = add(32'h304 + 32'(8 * i), 5'd6, 5'd1, 5'd5); tick(); tick();
    end
    chk("sat cnt", 32'(stall_count), 7);

    // reset asserted while stalling
    cur = lw(32'h400, 5'd5); tick();
    cur = add(32'h404, 5'd6, 5'd5, 5'd1); reset_n = 0; #1;
    chk("rst stall pre", 32'(ID_stall), 1);
    tick();
    chk("rst stall drop", 32'(ID_stall), 0); chk("rst cnt", 32'(stall_count), 0);
    reset_n = 1; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
